// File: rtl/mem_xfer_pkg.sv
// Shared types and sizing helpers for the mem_xfer responder.
package mem_xfer_pkg;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_FETCH  = 2'd1,
    RD_STREAM = 2'd2,
    RD_DONE   = 2'd3
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE   = 2'd0,
    WR_ACCEPT = 2'd1,
    WR_DONE   = 2'd2
  } wr_state_t;

  function automatic int unsigned BYTES_PER_BEAT(input int unsigned tdata_width);
    return tdata_width / 8;
  endfunction

  // Rounds up so a partial trailing beat still counts as a full beat.
  function automatic logic [63:0] beats_from_size(input logic [63:0] size,
                                                  input int unsigned bytes);
    logic [63:0] b;
    b = 64'(bytes);
    return (size + b - 64'd1) / b;
  endfunction

endpackage

// File: rtl/mem_xfer_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle latency, read-first).
module mem_xfer_sdp_ram #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // NOTE: the array is deliberately left without a reset so it maps onto block RAM;
  // only the read-data register is cleared.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // NOTE: non-blocking updates make a same-address read return the pre-write word.
  always_ff @(posedge clk) begin
    if (reset)   rdata_q <= '0;
    else if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_xfer_responder.sv
// Responder for the start/addr/size/data/valid/ready/done handshake, backed by an SDP RAM.
// Optional master-backpressure stimulus: define MEM_XFER_RESPONDER_STALL_EN.
module mem_xfer_responder
  import mem_xfer_pkg::*;
#(
  parameter int unsigned C_AXIS_TDATA_WIDTH = 256,
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
  parameter int unsigned C_XFER_SIZE_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH          = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rd_start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] rd_addr,
  input  logic [C_XFER_SIZE_WIDTH-1:0]  rd_size,
  output logic [C_AXIS_TDATA_WIDTH-1:0] rd_data,
  output logic                          rd_data_valid,
  input  logic                          rd_data_ready,
  output logic                          rd_done,
  output logic                          rd_busy,
  input  logic                          wr_start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] wr_addr,
  input  logic [C_XFER_SIZE_WIDTH-1:0]  wr_size,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] wr_data,
  input  logic                          wr_data_valid,
  output logic                          wr_data_ready,
  output logic                          wr_done,
  output logic                          wr_busy
);

  localparam int unsigned BYTES      = BYTES_PER_BEAT(C_AXIS_TDATA_WIDTH);
  localparam int unsigned LOG2_BYTES = $clog2(BYTES);
  localparam int unsigned IDX_W      = $clog2(MEM_DEPTH);
  localparam int unsigned XW         = C_XFER_SIZE_WIDTH;

  logic stall;

`ifdef MEM_XFER_RESPONDER_STALL_EN
  logic [7:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 8'hA5;
    else       lfsr_q <= lfsr_d;
  end

  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  logic [63:0]   rd_beats_full, wr_beats_full;
  logic [XW-1:0] rd_beats, wr_beats;

  assign rd_beats_full = beats_from_size(64'(rd_size), BYTES);
  assign wr_beats_full = beats_from_size(64'(wr_size), BYTES);
  assign rd_beats      = rd_beats_full[XW-1:0];
  assign wr_beats      = wr_beats_full[XW-1:0];

  logic unused_bits;
  assign unused_bits = ^{rd_beats_full[63:XW], wr_beats_full[63:XW],
                         rd_addr[LOG2_BYTES-1:0], rd_addr[C_M_AXI_ADDR_WIDTH-1:LOG2_BYTES+IDX_W],
                         wr_addr[LOG2_BYTES-1:0], wr_addr[C_M_AXI_ADDR_WIDTH-1:LOG2_BYTES+IDX_W]};

  // ---------------- read channel ----------------
  rd_state_t        rd_state_q, rd_state_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [XW-1:0]    rd_fetch_q, rd_fetch_d;   // beats still to be read from RAM
  logic [XW-1:0]    rd_left_q, rd_left_d;     // beats still to be handshaken
  logic             rd_valid_q, rd_valid_d;
  logic             rd_hs, ram_re;

  assign rd_hs = rd_valid_q & rd_data_ready;

  // NOTE: every always_comb output gets a default first so no path leaves a latch.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_idx_d   = rd_idx_q;
    rd_fetch_d = rd_fetch_q;
    rd_left_d  = rd_left_q;
    rd_valid_d = rd_valid_q;
    ram_re     = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        if (rd_start) begin
          rd_idx_d   = rd_addr[LOG2_BYTES +: IDX_W];
          rd_fetch_d = rd_beats;
          rd_left_d  = rd_beats;
          rd_state_d = (rd_beats == '0) ? RD_DONE : RD_FETCH;
        end
      end
      RD_FETCH, RD_STREAM: begin
        // The RAM output register doubles as the beat register, so only refill it when it frees up.
        ram_re = (rd_fetch_q != '0) && (!rd_valid_q || rd_hs) && !stall;
        if (ram_re) begin
          rd_idx_d   = rd_idx_q + IDX_W'(1);
          rd_fetch_d = rd_fetch_q - XW'(1);
          rd_state_d = RD_STREAM;
        end
        rd_valid_d = ram_re | (rd_valid_q & ~rd_hs);
        if (rd_hs) begin
          rd_left_d = rd_left_q - XW'(1);
          if (rd_left_q == XW'(1)) rd_state_d = RD_DONE;
        end
      end
      RD_DONE: rd_state_d = RD_IDLE;
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state_q <= RD_IDLE;
      rd_idx_q   <= '0;
      rd_fetch_q <= '0;
      rd_left_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_idx_q   <= rd_idx_d;
      rd_fetch_q <= rd_fetch_d;
      rd_left_q  <= rd_left_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data_valid = rd_valid_q;
  assign rd_done       = (rd_state_q == RD_DONE);
  assign rd_busy       = (rd_state_q != RD_IDLE);

  // ---------------- write channel ----------------
  wr_state_t        wr_state_q, wr_state_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [XW-1:0]    wr_left_q, wr_left_d;
  logic             wr_hs;

  assign wr_data_ready = (wr_state_q == WR_ACCEPT) && !stall;
  assign wr_hs         = wr_data_ready & wr_data_valid;

  always_comb begin
    wr_state_d = wr_state_q;
    wr_idx_d   = wr_idx_q;
    wr_left_d  = wr_left_q;
    case (wr_state_q)
      WR_IDLE: begin
        if (wr_start) begin
          wr_idx_d   = wr_addr[LOG2_BYTES +: IDX_W];
          wr_left_d  = wr_beats;
          wr_state_d = (wr_beats == '0) ? WR_DONE : WR_ACCEPT;
        end
      end
      WR_ACCEPT: begin
        if (wr_hs) begin
          wr_idx_d  = wr_idx_q + IDX_W'(1);
          wr_left_d = wr_left_q - XW'(1);
          if (wr_left_q == XW'(1)) wr_state_d = WR_DONE;
        end
      end
      WR_DONE: wr_state_d = WR_IDLE;
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state_q <= WR_IDLE;
      wr_idx_q   <= '0;
      wr_left_q  <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_idx_q   <= wr_idx_d;
      wr_left_q  <= wr_left_d;
    end
  end

  assign wr_done = (wr_state_q == WR_DONE);
  assign wr_busy = (wr_state_q != WR_IDLE);

  // A beat offered in the reset cycle belongs to an aborted transfer and must not land.
  mem_xfer_sdp_ram #(
    .WIDTH (C_AXIS_TDATA_WIDTH),
    .DEPTH (MEM_DEPTH)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_hs & ~reset),
    .waddr (wr_idx_q),
    .wdata (wr_data),
    .re    (ram_re),
    .raddr (rd_idx_q),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_mem_xfer_responder.sv
// Scoreboard bench for mem_xfer_responder: a RAM model feeds an expected-beat queue per read command.
`timescale 1ns/1ps
module tb_mem_xfer_responder;

  localparam int DW    = 256;
  localparam int AW    = 64;
  localparam int XW    = 32;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rd_start = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [XW-1:0] rd_size = '0;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
  logic          rd_data_ready = 1'b0;
  logic          rd_done, rd_busy;
  logic          wr_start = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [XW-1:0] wr_size = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_data_valid = 1'b0;
  logic          wr_data_ready, wr_done, wr_busy;

  always #5 clk = ~clk;

  mem_xfer_responder #(
    .C_AXIS_TDATA_WIDTH (DW),
    .C_M_AXI_ADDR_WIDTH (AW),
    .C_XFER_SIZE_WIDTH  (XW),
    .MEM_DEPTH          (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rd_start      (rd_start),
    .rd_addr       (rd_addr),
    .rd_size       (rd_size),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .rd_data_ready (rd_data_ready),
    .rd_done       (rd_done),
    .rd_busy       (rd_busy),
    .wr_start      (wr_start),
    .wr_addr       (wr_addr),
    .wr_size       (wr_size),
    .wr_data       (wr_data),
    .wr_data_valid (wr_data_valid),
    .wr_data_ready (wr_data_ready),
    .wr_done       (wr_done),
    .wr_busy       (wr_busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rd_done_cnt = 0, wr_done_cnt = 0;
  int cmd_beats = 0, first_cyc = -1, last_cyc = -1, done_cyc = -1;
  int rst_rd0, rst_wr0;
  logic          prev_v = 1'b0, prev_r = 1'b0;
  logic [DW-1:0] prev_d = '0;
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor samples on the falling edge, half a cycle away from the DUT's active edge.
  always @(negedge clk) begin
    if (reset) begin
      prev_v = 1'b0;
    end else begin
      if (prev_v && !prev_r) begin
        check("rd_hold_valid", rd_data_valid, 1);
        check("rd_hold_data", rd_data, prev_d);
      end
      if (rd_data_valid && rd_data_ready) begin
        if (exp_q.size() == 0) check("rd_extra_beat", rd_data_valid, 0);
        else                   check("rd_beat", rd_data, exp_q.pop_front());
        if (cmd_beats == 0) first_cyc = cyc;
        last_cyc = cyc;
        cmd_beats++;
      end
      if (rd_done) begin
        rd_done_cnt++;
        done_cyc = cyc;
      end
      if (wr_done) wr_done_cnt++;
      prev_v = rd_data_valid;
      prev_r = rd_data_ready;
      prev_d = rd_data;
    end
  end

  task automatic do_write(input logic [AW-1:0] addr, input logic [XW-1:0] size, input int base);
    int nb = int'((size + 32'd31) / 32'd32);
    int idx = int'(addr[14:5]);
    int sent = 0;
    int guard = 0;
    int d0 = wr_done_cnt;
    bit hs;
    wr_addr = addr; wr_size = size; wr_start = 1'b1; wr_data_valid = 1'b0;
    @(posedge clk); #1;
    wr_start = 1'b0;
    check("wr_busy_t1", wr_busy, 1);
    check("wr_ready_t1", wr_data_ready, nb > 0);
    check("wr_done_t1", wr_done, nb == 0);
    wr_data_valid = (nb > 0);
    wr_data = {8{32'(base)}};
    while (wr_done_cnt == d0 && guard < 300) begin
      @(negedge clk);
      hs = wr_data_valid && wr_data_ready;
      if (sent >= nb && wr_data_valid) check("wr_surplus_ready", wr_data_ready, 0);
      @(posedge clk); #1;
      guard++;
      if (hs) begin
        model[(idx + sent) % DEPTH] = wr_data;
        sent++;
      end
      wr_data = {8{32'(base + sent)}};
    end
    wr_data_valid = 1'b0;
    check("wr_no_timeout", guard < 300, 1);
    check("wr_beat_count", sent, nb);
    check("wr_busy_after_done", wr_busy, 0);
    check("wr_done_count", wr_done_cnt - d0, 1);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [XW-1:0] size,
                         input bit toggle, input bit poke);
    int nb = int'((size + 32'd31) / 32'd32);
    int idx = int'(addr[14:5]);
    int guard = 0;
    int d0, t0;
    for (int i = 0; i < nb; i++) exp_q.push_back(model[(idx + i) % DEPTH]);
    cmd_beats = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1;
    d0 = rd_done_cnt;
    rd_data_ready = 1'b1;
    rd_addr = addr; rd_size = size; rd_start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    rd_start = 1'b0;
    check("rd_busy_t1", rd_busy, 1);
    check("rd_done_t1", rd_done, nb == 0);
    while (rd_done_cnt == d0 && guard < 300) begin
      if (toggle) rd_data_ready = ~rd_data_ready;
      if (poke && guard == 2) begin
        rd_start = 1'b1; rd_addr = 64'h8000; rd_size = 32'd64;
      end else begin
        rd_start = 1'b0;
      end
      @(posedge clk); #1;
      guard++;
    end
    rd_start = 1'b0;
    rd_data_ready = 1'b1;
    check("rd_no_timeout", guard < 300, 1);
    check("rd_busy_after_done", rd_busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rd_done_count", rd_done_cnt - d0, 1);
    check("rd_beat_count", cmd_beats, nb);
    check("rd_queue_empty", exp_q.size(), 0);
    if (!toggle) begin
      if (nb > 0) begin
        check("rd_first_valid_cyc", first_cyc, t0 + 2);
        check("rd_last_beat_cyc", last_cyc, t0 + 1 + nb);
        check("rd_done_cyc", done_cyc, last_cyc + 1);
      end else begin
        check("rd_done_cyc", done_cyc, t0 + 1);
      end
    end
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_rd_data", rd_data, 0);
    check("rst_outputs", {rd_data_valid, rd_done, rd_busy, wr_data_ready, wr_done, wr_busy}, 0);

    // Basic write then read-back, full rate.
    do_write(64'h40, 32'd128, 1);
    do_read(64'h40, 32'd128, 1'b0, 1'b0);

    // Size not a multiple of the beat width rounds up.
    do_read(64'h40, 32'd100, 1'b0, 1'b0);

    // Index wrap past the last RAM word.
    do_write(64'(1022 * 32), 32'd128, 100);
    do_read(64'h0, 32'd64, 1'b0, 1'b0);

    // Backpressure: ready toggling every cycle.
    do_read(64'h40, 32'd128, 1'b1, 1'b0);

    // Same-word collision: read returns the old word, a later read the new one.
    do_write(64'(20 * 32), 32'd32, 500);
    fork
      do_write(64'(20 * 32), 32'd32, 600);
      do_read(64'(20 * 32), 32'd32, 1'b0, 1'b0);
    join
    do_read(64'(20 * 32), 32'd32, 1'b0, 1'b0);

    // Zero-size commands on both channels.
    fork
      do_write(64'h0, 32'd0, 0);
      do_read(64'h0, 32'd0, 1'b0, 1'b0);
    join

    // A second rd_start while busy is dropped.
    do_read(64'h40, 32'd128, 1'b0, 1'b1);

    // Reset in the middle of both transfers.
    rd_data_ready = 1'b0;
    rd_addr = 64'h40; rd_size = 32'd128; rd_start = 1'b1;
    wr_addr = 64'h2000; wr_size = 32'd128; wr_start = 1'b1; wr_data_valid = 1'b0;
    @(posedge clk); #1;
    rd_start = 1'b0; wr_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_valid", rd_data_valid, 1);
    rst_rd0 = rd_done_cnt;
    rst_wr0 = wr_done_cnt;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_rd_data", rd_data, 0);
    check("mid_rst_outputs", {rd_data_valid, rd_done, rd_busy, wr_data_ready, wr_done, wr_busy}, 0);
    rd_data_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("mid_rst_no_done", (rd_done_cnt - rst_rd0) + (wr_done_cnt - rst_wr0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
